// File: rtl/fifo_s1_rd_ctrl.sv
// Read-side controller for a single-clock FIFO: pops words into a 2-entry skid buffer and presents them on a valid/ready stream.
// Optional pop counter (clr_count/pop_count) is built when FIFO_RD_POP_CNT_EN is defined.
module fifo_s1_rd_ctrl #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_error,
  output logic             fifo_pop_req_n,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             rd_err
`ifdef FIFO_RD_POP_CNT_EN
  ,
  input  logic                 clr_count,
  output logic [CNT_WIDTH-1:0] pop_count
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic             pop;
  logic             deq;

  // Pop is gated by rst directly so the request drops the instant reset asserts.
  assign pop            = !rst && !fifo_empty && (state != ST_TWO);
  assign fifo_pop_req_n = ~pop;
  assign m_valid        = (state != ST_EMPTY);
  assign m_data         = head;
  assign deq            = m_valid && m_ready;

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // below reads the pre-edge values of state/head/skid regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (pop) begin
            head  <= fifo_data_out;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (pop && deq) begin
            head <= fifo_data_out;
          end else if (pop) begin
            skid  <= fifo_data_out;
            state <= ST_TWO;
          end else if (deq) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // No pop happens here, so the skid word is the next in order.
          if (deq) begin
            head  <= skid;
            state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_err <= 1'b0;
    end else if (fifo_error) begin
      rd_err <= 1'b1;
    end
  end

`ifdef FIFO_RD_POP_CNT_EN
  // Clear wins over a simultaneous pop; the count wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_count <= '0;
    end else if (clr_count) begin
      pop_count <= '0;
    end else if (pop) begin
      pop_count <= pop_count + 1'b1;
    end
  end
`endif

endmodule
